// File: rtl/sub_sched.sv
// Two-requester round-robin subtract/add scheduler sharing one WIDTH-bit adder.
// Define SUB_SCHED_TWOS_EN for single-pass two's-complement subtraction; the default is two-pass ones' complement.
module sub_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       REQ_VALID,
  output logic [1:0]       REQ_READY,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             OP0,
  input  logic             OP1,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             RES_ID
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t           state;
  logic             prio;
  logic             phase;
  logic             id_q;
  logic             op_q;
  logic             c1;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y1;
  logic [1:0]       grant;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             carry;

  always_comb begin
    grant = '0;
    case (REQ_VALID)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Gated with rst_n so no strobe is offered while reset is held.
  assign REQ_READY = (state == IDLE && rst_n) ? grant : '0;

  always_comb begin
    add_x   = a_q;
    add_y   = op_q ? ~b_q : b_q;
`ifdef SUB_SCHED_TWOS_EN
    add_cin = op_q;
`else
    add_cin = 1'b0;
`endif
    if (state == PASS2) begin
      add_x   = y1;
      add_y   = '0;
      add_cin = c1;
    end
    {carry, sum} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  end

  // PASS1 spans two cycles: phase 0 registers Y1/C1, phase 1 consumes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      phase     <= 1'b0;
      id_q      <= 1'b0;
      op_q      <= 1'b0;
      c1        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      y1        <= '0;
      RES_VALID <= 1'b0;
      S         <= '0;
      COUT      <= 1'b0;
      RES_ID    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(REQ_VALID & REQ_READY)) begin
            id_q  <= REQ_READY[1];
            a_q   <= REQ_READY[1] ? A1 : A0;
            b_q   <= REQ_READY[1] ? B1 : B0;
            op_q  <= REQ_READY[1] ? OP1 : OP0;
            prio  <= ~REQ_READY[1];
            phase <= 1'b0;
            state <= PASS1;
          end
        end
        PASS1: begin
          if (!phase) begin
            y1    <= sum;
            c1    <= carry;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!op_q) begin
              S         <= y1;
              COUT      <= c1;
              RES_ID    <= id_q;
              RES_VALID <= 1'b1;
              state     <= DONE;
            end else begin
`ifdef SUB_SCHED_TWOS_EN
              S         <= y1;
              COUT      <= ~c1;
              RES_ID    <= id_q;
              RES_VALID <= 1'b1;
              state     <= DONE;
`else
              state     <= PASS2;
`endif
            end
          end
        end
        PASS2: begin
          S         <= sum;
          COUT      <= ~c1;
          RES_ID    <= id_q;
          RES_VALID <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_sched.sv
// Directed self-checking bench for sub_sched; expectations follow SUB_SCHED_TWOS_EN when it is defined.
module tb_sub_sched;
  localparam int W = 4;

`ifdef SUB_SCHED_TWOS_EN
  localparam int SUB_LAT = 2;
  localparam int NEG_S   = 14;
  localparam int EQ_S    = 0;
  localparam int EQ_C    = 0;
  localparam int RST_AT  = 2;
`else
  localparam int SUB_LAT = 3;
  localparam int NEG_S   = 13;
  localparam int EQ_S    = 15;
  localparam int EQ_C    = 1;
  localparam int RST_AT  = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   REQ_VALID;
  logic [1:0]   REQ_READY;
  logic [W-1:0] A0, B0, A1, B1;
  logic         OP0, OP1;
  logic         RES_VALID;
  logic         RES_READY;
  logic [W-1:0] S;
  logic         COUT;
  logic         RES_ID;

  int checks = 0;
  int errors = 0;

  sub_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .OP0(OP0), .OP1(OP1),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .S(S), .COUT(COUT), .RES_ID(RES_ID)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    if (id) begin
      A1 = a; B1 = b; OP1 = op;
    end else begin
      A0 = a; B0 = b; OP0 = op;
    end
  endtask

  // Called on the first falling edge after the accept edge; lat counts rising edges after accept.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (RES_VALID !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    RES_READY = 1'b1;
    @(negedge clk);
    RES_READY = 1'b0;
    chk("res_valid_clear", 32'(RES_VALID), 0);
  endtask

  task automatic do_op(input string tag, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input int exp_s, input int exp_c, input int exp_lat);
    int lat;
    drive(id, a, b, op);
    REQ_VALID = id ? 2'b10 : 2'b01;
    #1;
    chk({tag, "_ready"}, 32'(REQ_READY), id ? 2 : 1);
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = '0;
    drive(id, ~a, a ^ b, ~op);
    chk({tag, "_busy_ready"}, 32'(REQ_READY), 0);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_s"}, 32'(S), exp_s);
    chk({tag, "_cout"}, 32'(COUT), exp_c);
    chk({tag, "_id"}, 32'(RES_ID), 32'(id));
    consume();
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; REQ_VALID = 2'b11; RES_READY = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0; OP0 = 1'b0; OP1 = 1'b0;
    #2;
    chk("rst_ready", 32'(REQ_READY), 0);
    chk("rst_valid", 32'(RES_VALID), 0);
    chk("rst_s", 32'(S), 0);
    chk("rst_cout", 32'(COUT), 0);
    chk("rst_id", 32'(RES_ID), 0);
    @(negedge clk);
    REQ_VALID = '0;
    rst_n = 1'b1;
    @(negedge clk);
    REQ_VALID = 2'b11;
    #1;
    chk("rst_prio", 32'(REQ_READY), 1);
    REQ_VALID = '0;
    @(negedge clk);

    do_op("sub_5_3", 1'b0, 4'd5, 4'd3, 1'b1, 2, 0, SUB_LAT);
    do_op("sub_3_5", 1'b1, 4'd3, 4'd5, 1'b1, NEG_S, 1, SUB_LAT);
    do_op("add_9_8", 1'b0, 4'd9, 4'd8, 1'b0, 1, 1, 2);
    do_op("sub_eq", 1'b1, 4'd6, 4'd6, 1'b1, EQ_S, EQ_C, SUB_LAT);

    // Both requesters held valid: grants alternate starting with requester 0.
    drive(1'b0, 4'd1, 4'd2, 1'b0);
    drive(1'b1, 4'd7, 4'd2, 1'b0);
    REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(REQ_READY), (k % 2) ? 2 : 1);
      @(posedge clk);
      @(negedge clk);
      wait_valid(lat);
      chk("rr_id", 32'(RES_ID), k % 2);
      chk("rr_s", 32'(S), (k % 2) ? 9 : 3);
      RES_READY = 1'b1;
      @(negedge clk);
      RES_READY = 1'b0;
    end
    REQ_VALID = '0;
    @(negedge clk);

    // Result held in DONE while RES_READY stays low.
    drive(1'b0, 4'd2, 4'd3, 1'b0);
    REQ_VALID = 2'b01;
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = '0;
    wait_valid(lat);
    chk("hold_lat", lat, 2);
    REQ_VALID = 2'b11;
    repeat (5) begin
      @(negedge clk);
      chk("hold_s", 32'(S), 5);
      chk("hold_cout", 32'(COUT), 0);
      chk("hold_id", 32'(RES_ID), 0);
      chk("hold_valid", 32'(RES_VALID), 1);
      chk("hold_ready", 32'(REQ_READY), 0);
    end
    RES_READY = 1'b1;
    @(negedge clk);
    RES_READY = 1'b0;
    chk("hold_release_valid", 32'(RES_VALID), 0);
    chk("hold_release_grant", 32'(REQ_READY), 2);
    REQ_VALID = '0;
    @(negedge clk);

    // Abort an in-flight subtract with reset; requester 0 granted so the pointer moves to 1 first.
    drive(1'b0, 4'd5, 4'd3, 1'b1);
    REQ_VALID = 2'b01;
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = '0;
    repeat (RST_AT - 1) @(negedge clk);
    chk("abort_pre_valid", 32'(RES_VALID), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_s", 32'(S), 0);
    chk("abort_cout", 32'(COUT), 0);
    chk("abort_id", 32'(RES_ID), 0);
    chk("abort_valid", 32'(RES_VALID), 0);
    chk("abort_ready", 32'(REQ_READY), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_result", 32'(RES_VALID), 0);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    REQ_VALID = 2'b11;
    #1;
    chk("abort_next_grant", 32'(REQ_READY), 1);
    @(posedge clk);
    @(negedge clk);
    REQ_VALID = '0;
    wait_valid(lat);
    chk("abort_next_id", 32'(RES_ID), 0);
    chk("abort_next_s", 32'(S), 2);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
